simple_if_mst_seq: RTL and testbench
====================================

// Module: simple_if_mst_seq
// PURPOSE
//  Initiator (master) end of simple_if: accepts read/write commands on a valid/ready stream,
//  buffers them, and issues them one at a time on a simple_if.mst_port. Waits for
//  rd_data_vld with a timeout and returns one response per read command.
//  Sits between a CPU/test-sequencer command source and any simple_if slave.
// PARAMETERS
//  ADDR_BIT_WIDTH   2   address width; must match the connected simple_if
//  DATA_BIT_WIDTH   8   data width; must match the connected simple_if
//  CMD_FIFO_DEPTH   4   command buffer depth; power of 2, >=2
//  RD_TIMEOUT_CYC   16  max cycles spent waiting for rd_data_vld; >=1
// PORTS
//  i_clk            in   1       clock; all logic is on the rising edge
//  i_arst_n         in   1       asynchronous active-low reset
//  i_cmd_vld        in   1       command valid
//  o_cmd_rdy        out  1       command ready (= FIFO not full)
//  i_cmd_is_wr      in   1       1: write, 0: read
//  i_cmd_addr       in   ADDR    target address
//  i_cmd_wr_data    in   DATA    write data (ignored for reads)
//  o_rsp_vld        out  1       read response valid
//  i_rsp_rdy        in   1       read response ready
//  o_rsp_rd_data    out  DATA    read-back data (0 on timeout)
//  o_rsp_timeout    out  1       1: no rd_data_vld within RD_TIMEOUT_CYC
//  o_busy           out  1       FSM not IDLE or FIFO not empty
//  o_stray_vld_cnt  out  8       count of rd_data_vld seen outside WAIT_RD, saturating at 255
//  if_mst           simple_if.mst_port  bus to the slave
// BEHAVIOUR
//  Reset (async assert, sync release): FSM=IDLE, FIFO empty, all outputs and bus outputs 0
//   (addr, wr_data, rd_req, wr_req, rsp_*, counters). o_cmd_rdy=0 while reset is asserted.
//   Reset mid-transaction: the transaction is abandoned and no response is produced.
//  Cmd handshake: i_cmd_vld & o_cmd_rdy at edge k writes the FIFO. Full: o_cmd_rdy=0, no write.
//   Simultaneous push+pop when full is not accepted (rdy depends on full only).
//  All bus outputs come straight from registers. FSM states:
//   IDLE: FIFO non-empty -> pop, latch addr/wr_data/is_wr -> ISSUE. Otherwise stay.
//   ISSUE: drive wr_req or rd_req for exactly 1 cycle with addr (and wr_data).
//          Write -> IDLE (no response). Read -> WAIT_RD with timeout cnt=0.
//   WAIT_RD: req=0. rd_data_vld=1 -> capture rd_data, timeout=0 -> RSP.
//          Else if cnt==RD_TIMEOUT_CYC-1 -> data=0, timeout=1 -> RSP. Else cnt++.
//          vld on the final count cycle wins over timeout.
//   RSP: o_rsp_vld=1, data and timeout held stable until i_rsp_rdy=1 -> IDLE (vld=0 next cycle).
//  Latency: cmd handshake at edge k -> req high in the cycle after edge k+1. Read with slave
//   vld in the cycle after rd_req -> o_rsp_vld high in the cycle after that.
//   Write throughput: 1 per 2 cycles.
//  rd_data_vld during IDLE, ISSUE, or RSP: ignored for data; o_stray_vld_cnt++ (sat 255).
//  rd_req and wr_req are never asserted together; addr and wr_data hold their last values when idle.
//  o_busy = (state!=IDLE) | ~fifo_empty.
// STRUCTURE
//  Package simple_if_mst_seq_pkg: typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RD, RSP} state_t;
//   localparam STRAY_CNT_W = 8. The command word is a local packed struct, because its
//   width depends on the parameters.
//  Sub-module simple_if_cmd_fifo: sync FIFO, DEPTH and WIDTH parameters, registered
//   empty/full, same clock and reset. FSM, timeout counter and stray counter live in this module.
// TESTING
//  1 Write a=2,d=0xA5 -> wr_req=1 for 1 cycle, 2 cycles after handshake, addr=2,
//    wr_data=0xA5; no rsp.
//  2 Read a=1, slave vld 3 cycles after rd_req with 0x3C -> one rsp: data=0x3C,
//    timeout=0.
//  3 Read, slave silent -> rsp after RD_TIMEOUT_CYC wait cycles: timeout=1, data=0.
//    Vld on the final cycle -> timeout=0.
//  4 Push 5 cmds back-to-back, DEPTH=4, FSM stalled in RSP (rsp_rdy=0) -> o_cmd_rdy=0
//    once full; order preserved; rsp stable while stalled.
//  5 Pulse rd_data_vld 3x while IDLE -> o_stray_vld_cnt=3, no rsp. Force 300 pulses
//    -> count saturates at 255.
//  6 Assert i_arst_n=0 during WAIT_RD -> all outputs 0 immediately; after release,
//    no rsp and FIFO empty.

Source files
------------

// File: rtl/simple_if_mst_seq_pkg.sv
// Shared types and helpers for the simple_if initiator: FSM state encoding
// and the saturating stray-valid counter.
package simple_if_mst_seq_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT_RD = 2'd2,
    RSP     = 2'd3
  } state_t;

  localparam int STRAY_CNT_W = 8;

  function automatic logic [STRAY_CNT_W-1:0] sat_inc(input logic [STRAY_CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/simple_if.sv
// Simple register-style bus: one-cycle rd_req/wr_req strobes from the
// initiator, rd_data qualified by rd_data_vld from the target.
interface simple_if #(
  parameter int ADDR_BIT_WIDTH = 2,
  parameter int DATA_BIT_WIDTH = 8
) ();
  logic [ADDR_BIT_WIDTH-1:0] addr;
  logic [DATA_BIT_WIDTH-1:0] wr_data;
  logic                      rd_req;
  logic                      wr_req;
  logic [DATA_BIT_WIDTH-1:0] rd_data;
  logic                      rd_data_vld;

  modport mst_port (
    output addr, wr_data, rd_req, wr_req,
    input  rd_data, rd_data_vld
  );

  modport slv_port (
    input  addr, wr_data, rd_req, wr_req,
    output rd_data, rd_data_vld
  );
endinterface

// File: rtl/simple_if_cmd_fifo.sv
// Synchronous command FIFO with registered empty/full flags; the head entry
// is always visible on o_pop_data so the consumer can latch it on pop.
module simple_if_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_arst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_pop_data,
  output logic             o_empty,
  output logic             o_full
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic [AW:0]      count_nxt;
  logic             push_ok;
  logic             pop_ok;

  assign push_ok    = i_push & ~o_full;
  assign pop_ok     = i_pop & ~o_empty;
  assign o_pop_data = mem[rd_ptr];

  always_comb begin
    count_nxt = count;
    if (push_ok && !pop_ok)      count_nxt = count + 1'b1;
    else if (pop_ok && !push_ok) count_nxt = count - 1'b1;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      o_empty <= 1'b1;
      o_full  <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      count   <= count_nxt;
      o_empty <= (count_nxt == '0);
      o_full  <= (count_nxt == DEPTH_CNT);
    end
  end

  always_ff @(posedge i_clk) begin
    if (push_ok) mem[wr_ptr] <= i_push_data;
  end

endmodule

// File: rtl/simple_if_mst_seq.sv
// Initiator end of simple_if: buffers read/write commands and issues them one
// at a time, returning one response (data or timeout) per read.
module simple_if_mst_seq
  import simple_if_mst_seq_pkg::*;
#(
  parameter int ADDR_BIT_WIDTH = 2,
  parameter int DATA_BIT_WIDTH = 8,
  parameter int CMD_FIFO_DEPTH = 4,
  parameter int RD_TIMEOUT_CYC = 16
) (
  input  logic                      i_clk,
  input  logic                      i_arst_n,
  // Streams use valid/ready: a transfer happens at a rising edge where both are
  // high; the source holds payload stable while valid is high and not accepted.
  input  logic                      i_cmd_vld,
  output logic                      o_cmd_rdy,
  input  logic                      i_cmd_is_wr,
  input  logic [ADDR_BIT_WIDTH-1:0] i_cmd_addr,
  input  logic [DATA_BIT_WIDTH-1:0] i_cmd_wr_data,
  output logic                      o_rsp_vld,
  input  logic                      i_rsp_rdy,
  output logic [DATA_BIT_WIDTH-1:0] o_rsp_rd_data,
  output logic                      o_rsp_timeout,
  output logic                      o_busy,
  output logic [STRAY_CNT_W-1:0]    o_stray_vld_cnt,
  output state_t                    o_dbg_state,
  simple_if.mst_port                if_mst
);
  typedef struct packed {
    logic                      is_wr;
    logic [ADDR_BIT_WIDTH-1:0] addr;
    logic [DATA_BIT_WIDTH-1:0] wr_data;
  } cmd_t;

  localparam int CMD_W = $bits(cmd_t);
  localparam int TW    = (RD_TIMEOUT_CYC > 1) ? $clog2(RD_TIMEOUT_CYC) : 1;
  localparam logic [TW-1:0] TO_LAST = TW'(RD_TIMEOUT_CYC - 1);

  state_t                    state;
  cmd_t                      head;
  logic                      fifo_empty;
  logic                      fifo_full;
  logic                      fifo_pop;
  logic                      rst_done;
  logic                      is_wr_q;
  logic [TW-1:0]             to_cnt;
  logic [ADDR_BIT_WIDTH-1:0] addr_q;
  logic [DATA_BIT_WIDTH-1:0] wr_data_q;
  logic                      rd_req_q;
  logic                      wr_req_q;

  // rst_done keeps ready low while reset is asserted, independent of full.
  assign o_cmd_rdy   = rst_done & ~fifo_full;
  assign fifo_pop    = (state == IDLE) & ~fifo_empty;
  assign o_busy      = (state != IDLE) | ~fifo_empty;
  assign o_dbg_state = state;

  assign if_mst.addr    = addr_q;
  assign if_mst.wr_data = wr_data_q;
  assign if_mst.rd_req  = rd_req_q;
  assign if_mst.wr_req  = wr_req_q;

  simple_if_cmd_fifo #(
    .DEPTH (CMD_FIFO_DEPTH),
    .WIDTH (CMD_W)
  ) u_cmd_fifo (
    .i_clk       (i_clk),
    .i_arst_n    (i_arst_n),
    .i_push      (i_cmd_vld & o_cmd_rdy),
    .i_push_data ({i_cmd_is_wr, i_cmd_addr, i_cmd_wr_data}),
    .i_pop       (fifo_pop),
    .o_pop_data  (head),
    .o_empty     (fifo_empty),
    .o_full      (fifo_full)
  );

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      state           <= IDLE;
      rst_done        <= 1'b0;
      is_wr_q         <= 1'b0;
      to_cnt          <= '0;
      addr_q          <= '0;
      wr_data_q       <= '0;
      rd_req_q        <= 1'b0;
      wr_req_q        <= 1'b0;
      o_rsp_vld       <= 1'b0;
      o_rsp_rd_data   <= '0;
      o_rsp_timeout   <= 1'b0;
      o_stray_vld_cnt <= '0;
    end else begin
      rst_done <= 1'b1;
      if (if_mst.rd_data_vld && state != WAIT_RD)
        o_stray_vld_cnt <= sat_inc(o_stray_vld_cnt);
      case (state)
        IDLE: begin
          if (!fifo_empty) begin
            addr_q    <= head.addr;
            wr_data_q <= head.wr_data;
            is_wr_q   <= head.is_wr;
            wr_req_q  <= head.is_wr;
            rd_req_q  <= ~head.is_wr;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          wr_req_q <= 1'b0;
          rd_req_q <= 1'b0;
          to_cnt   <= '0;
          state    <= is_wr_q ? IDLE : WAIT_RD;
        end
        WAIT_RD: begin
          // A valid on the last counted cycle still counts as a real response.
          if (if_mst.rd_data_vld) begin
            o_rsp_rd_data <= if_mst.rd_data;
            o_rsp_timeout <= 1'b0;
            o_rsp_vld     <= 1'b1;
            state         <= RSP;
          end else if (to_cnt == TO_LAST) begin
            o_rsp_rd_data <= '0;
            o_rsp_timeout <= 1'b1;
            o_rsp_vld     <= 1'b1;
            state         <= RSP;
          end else begin
            to_cnt <= to_cnt + TW'(1);
          end
        end
        RSP: begin
          if (i_rsp_rdy) begin
            o_rsp_vld <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_simple_if_mst_seq.sv
// Self-checking bench for simple_if_mst_seq with a cycle-stepped slave model
// and scoreboards for bus transactions and read responses.
module tb_simple_if_mst_seq;
  import simple_if_mst_seq_pkg::*;

  localparam int T = 16;

  logic       clk;
  logic       arst_n;
  logic       cmd_vld;
  logic       cmd_rdy;
  logic       cmd_is_wr;
  logic [1:0] cmd_addr;
  logic [7:0] cmd_wr_data;
  logic       rsp_vld;
  logic       rsp_rdy;
  logic [7:0] rsp_rd_data;
  logic       rsp_timeout;
  logic       busy;
  logic [7:0] stray_cnt;
  state_t     dbg_state;

  logic       slv_vld;
  logic       tb_vld;
  logic [7:0] slv_data;
  int         slv_cnt;

  int total;
  int bad;
  logic prev_req;

  logic [10:0] exp_bus_q[$];   // {is_wr, addr, wr_data (0 for reads)}
  logic [8:0]  exp_rsp_q[$];   // {timeout, rd_data}
  logic [16:0] slv_q[$];       // {silent, delay, data}

  simple_if #(.ADDR_BIT_WIDTH(2), .DATA_BIT_WIDTH(8)) bus ();

  assign bus.rd_data_vld = slv_vld | tb_vld;
  assign bus.rd_data     = slv_data;

  simple_if_mst_seq #(
    .ADDR_BIT_WIDTH (2),
    .DATA_BIT_WIDTH (8),
    .CMD_FIFO_DEPTH (4),
    .RD_TIMEOUT_CYC (T)
  ) dut (
    .i_clk           (clk),
    .i_arst_n        (arst_n),
    .i_cmd_vld       (cmd_vld),
    .o_cmd_rdy       (cmd_rdy),
    .i_cmd_is_wr     (cmd_is_wr),
    .i_cmd_addr      (cmd_addr),
    .i_cmd_wr_data   (cmd_wr_data),
    .o_rsp_vld       (rsp_vld),
    .i_rsp_rdy       (rsp_rdy),
    .o_rsp_rd_data   (rsp_rd_data),
    .o_rsp_timeout   (rsp_timeout),
    .o_busy          (busy),
    .o_stray_vld_cnt (stray_cnt),
    .o_dbg_state     (dbg_state),
    .if_mst          (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock cycle: scoreboard checks mid-cycle, then the slave model steps
  // just after the rising edge.
  task automatic tick();
    logic [10:0] eb;
    logic [8:0]  er;
    logic [16:0] se;
    @(negedge clk);
    if (bus.rd_req === 1'b1 || bus.wr_req === 1'b1) begin
      total++;
      if ({bus.rd_req, bus.wr_req} === 2'b11 || prev_req) begin
        bad++;
        $display("FAIL req_shape: rd_req=%b wr_req=%b prev_req=%b required single one-cycle strobe",
                 bus.rd_req, bus.wr_req, prev_req);
      end
      total++;
      if (exp_bus_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_req: addr=%0h required no request", bus.addr);
      end else begin
        eb = exp_bus_q.pop_front();
        if ({bus.wr_req, bus.addr, (bus.wr_req ? bus.wr_data : 8'h00)} !== eb) begin
          bad++;
          $display("FAIL bus_txn: got wr=%b addr=%0h data=%0h required %0h",
                   bus.wr_req, bus.addr, bus.wr_data, eb);
        end
      end
    end
    prev_req = bus.rd_req | bus.wr_req;
    if (rsp_vld === 1'b1 && rsp_rdy === 1'b1) begin
      total++;
      if (exp_rsp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_rsp: data=%0h timeout=%b required no response", rsp_rd_data, rsp_timeout);
      end else begin
        er = exp_rsp_q.pop_front();
        if ({rsp_timeout, rsp_rd_data} !== er) begin
          bad++;
          $display("FAIL rsp: got timeout=%b data=%0h required %0h", rsp_timeout, rsp_rd_data, er);
        end
      end
    end
    @(posedge clk);
    #1;
    slv_vld = 1'b0;
    if (slv_cnt > 0) begin
      slv_cnt--;
      if (slv_cnt == 0) slv_vld = 1'b1;
    end
    if (bus.rd_req === 1'b1 && slv_q.size() > 0) begin
      se = slv_q.pop_front();
      if (!se[16]) begin
        slv_cnt  = int'(se[15:8]);
        slv_data = se[7:0];
      end
    end
  endtask

  task automatic send_cmd(input logic is_wr, input logic [1:0] addr, input logic [7:0] data);
    logic acc;
    int   n;
    cmd_vld = 1'b1; cmd_is_wr = is_wr; cmd_addr = addr; cmd_wr_data = data;
    acc = 1'b0; n = 0;
    while (!acc && n < 60) begin
      acc = cmd_rdy;
      tick();
      n++;
    end
    cmd_vld = 1'b0;
    total++;
    if (!acc) begin
      bad++;
      $display("FAIL cmd_accept: rdy never seen after %0d cycles, required acceptance", n);
    end else begin
      exp_bus_q.push_back({is_wr, addr, (is_wr ? data : 8'h00)});
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((exp_rsp_q.size() != 0 || exp_bus_q.size() != 0 || busy || rsp_vld) && n < 200) begin
      tick();
      n++;
    end
    total++;
    if (n >= 200) begin
      bad++;
      $display("FAIL drain: bus_q=%0d rsp_q=%0d busy=%b required all drained",
               exp_bus_q.size(), exp_rsp_q.size(), busy);
    end
  endtask

  task automatic test_reset();
    arst_n = 1'b0;
    tick();
    total++;
    if ({cmd_rdy, rsp_vld, rsp_rd_data, rsp_timeout, busy, stray_cnt, bus.addr, bus.wr_data,
         bus.rd_req, bus.wr_req, dbg_state} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: rdy=%b rsp=%b data=%0h to=%b busy=%b stray=%0d addr=%0h wd=%0h rq=%b wq=%b st=%0d required all 0",
               cmd_rdy, rsp_vld, rsp_rd_data, rsp_timeout, busy, stray_cnt, bus.addr, bus.wr_data,
               bus.rd_req, bus.wr_req, dbg_state);
    end
    tick();
    arst_n = 1'b1;
    tick();
    total++;
    if ({cmd_rdy, busy} !== 2'b10) begin
      bad++;
      $display("FAIL post_reset: rdy=%b busy=%b required rdy=1 busy=0", cmd_rdy, busy);
    end
  endtask

  task automatic test_write();
    send_cmd(1'b1, 2'd2, 8'hA5);
    total++;
    if (bus.wr_req !== 1'b0) begin
      bad++; $display("FAIL wr_early: wr_req=%b required 0 one cycle after handshake", bus.wr_req);
    end
    tick();
    total++;
    if ({bus.wr_req, bus.rd_req, bus.addr, bus.wr_data} !== {2'b10, 2'd2, 8'hA5}) begin
      bad++;
      $display("FAIL wr_issue: wr=%b rd=%b addr=%0h data=%0h required wr=1 rd=0 addr=2 data=a5",
               bus.wr_req, bus.rd_req, bus.addr, bus.wr_data);
    end
    tick();
    total++;
    if ({bus.wr_req, bus.addr, bus.wr_data} !== {1'b0, 2'd2, 8'hA5}) begin
      bad++;
      $display("FAIL wr_end: wr=%b addr=%0h data=%0h required wr=0 with addr/data held",
               bus.wr_req, bus.addr, bus.wr_data);
    end
    repeat (4) tick();
    wait_idle();
  endtask

  task automatic test_read_latency();
    slv_q.push_back({1'b0, 8'd1, 8'h5A});
    exp_rsp_q.push_back({1'b0, 8'h5A});
    send_cmd(1'b0, 2'd3, 8'h00);
    tick();
    total++;
    if ({bus.rd_req, bus.addr} !== {1'b1, 2'd3}) begin
      bad++; $display("FAIL rd_issue: rd=%b addr=%0h required rd=1 addr=3", bus.rd_req, bus.addr);
    end
    tick();
    tick();
    total++;
    if ({rsp_vld, rsp_timeout, rsp_rd_data} !== {2'b10, 8'h5A}) begin
      bad++;
      $display("FAIL rd_latency: vld=%b to=%b data=%0h required vld=1 to=0 data=5a",
               rsp_vld, rsp_timeout, rsp_rd_data);
    end
    tick();
    total++;
    if (rsp_vld !== 1'b0) begin
      bad++; $display("FAIL rsp_drop: vld=%b required 0 after handshake", rsp_vld);
    end
    wait_idle();
  endtask

  task automatic test_read();
    slv_q.push_back({1'b0, 8'd3, 8'h3C});
    exp_rsp_q.push_back({1'b0, 8'h3C});
    send_cmd(1'b0, 2'd1, 8'h00);
    wait_idle();
  endtask

  task automatic test_timeout(input logic silent, input logic [7:0] data);
    logic seen;
    slv_q.push_back({silent, 8'(T), data});
    exp_rsp_q.push_back(silent ? 9'h100 : {1'b0, data});
    send_cmd(1'b0, 2'd0, 8'h00);
    tick();
    seen = 1'b0;
    repeat (T) begin
      tick();
      seen = seen | rsp_vld;
    end
    total++;
    if (seen !== 1'b0) begin
      bad++; $display("FAIL to_early: rsp_vld seen during wait, required none for %0d cycles", T);
    end
    tick();
    total++;
    if ({rsp_vld, rsp_timeout, rsp_rd_data} !== {1'b1, silent, (silent ? 8'h00 : data)}) begin
      bad++;
      $display("FAIL to_rsp: vld=%b to=%b data=%0h required vld=1 to=%b data=%0h",
               rsp_vld, rsp_timeout, rsp_rd_data, silent, (silent ? 8'h00 : data));
    end
    wait_idle();
  endtask

  task automatic test_back_to_back();
    logic [1:0] a [5];
    logic [7:0] d [5];
    for (int i = 0; i < 5; i++) begin
      a[i] = 2'($urandom_range(0, 3));
      d[i] = 8'($urandom_range(0, 255));
    end
    rsp_rdy = 1'b0;
    slv_q.push_back({1'b0, 8'd1, 8'h11});
    exp_rsp_q.push_back({1'b0, 8'h11});
    send_cmd(1'b0, 2'd1, 8'h00);
    for (int i = 0; i < 4; i++) send_cmd(1'b1, a[i], d[i]);
    cmd_vld = 1'b1; cmd_is_wr = 1'b1; cmd_addr = a[4]; cmd_wr_data = d[4];
    for (int i = 0; i < 6; i++) begin
      total++;
      if ({cmd_rdy, rsp_vld, rsp_timeout, rsp_rd_data} !== {2'b01, 1'b0, 8'h11}) begin
        bad++;
        $display("FAIL stall[%0d]: rdy=%b vld=%b to=%b data=%0h required rdy=0 vld=1 to=0 data=11",
                 i, cmd_rdy, rsp_vld, rsp_timeout, rsp_rd_data);
      end
      tick();
    end
    rsp_rdy = 1'b1;
    send_cmd(1'b1, a[4], d[4]);
    wait_idle();
  endtask

  task automatic test_stray();
    for (int i = 0; i < 3; i++) begin
      tb_vld = 1'b1; tick();
      tb_vld = 1'b0; tick();
    end
    total++;
    if ({stray_cnt, rsp_vld, busy} !== {8'd3, 2'b00}) begin
      bad++; $display("FAIL stray3: cnt=%0d vld=%b busy=%b required cnt=3 vld=0 busy=0", stray_cnt, rsp_vld, busy);
    end
    tb_vld = 1'b1; repeat (251) tick();
    tb_vld = 1'b0; tick();
    total++;
    if (stray_cnt !== 8'd254) begin
      bad++; $display("FAIL stray254: cnt=%0d required 254", stray_cnt);
    end
    tb_vld = 1'b1; repeat (49) tick();
    tb_vld = 1'b0; tick();
    total++;
    if (stray_cnt !== 8'd255) begin
      bad++; $display("FAIL stray_sat: cnt=%0d required 255", stray_cnt);
    end
  endtask

  task automatic test_reset_mid();
    slv_q.push_back({1'b1, 8'd0, 8'h00});
    send_cmd(1'b0, 2'd2, 8'h00);
    tick();
    tick();
    total++;
    if (dbg_state !== WAIT_RD) begin
      bad++; $display("FAIL mid_state: state=%0d required WAIT_RD", dbg_state);
    end
    arst_n = 1'b0;
    #1;
    total++;
    if ({cmd_rdy, rsp_vld, rsp_rd_data, rsp_timeout, busy, stray_cnt, bus.addr, bus.wr_data,
         bus.rd_req, bus.wr_req, dbg_state} !== '0) begin
      bad++;
      $display("FAIL mid_reset: rdy=%b rsp=%b to=%b busy=%b stray=%0d addr=%0h st=%0d required all 0",
               cmd_rdy, rsp_vld, rsp_timeout, busy, stray_cnt, bus.addr, dbg_state);
    end
    tick();
    tick();
    arst_n = 1'b1;
    repeat (T + 4) tick();
    total++;
    if ({cmd_rdy, rsp_vld, busy, dbg_state} !== {3'b100, IDLE}) begin
      bad++;
      $display("FAIL after_reset: rdy=%b vld=%b busy=%b st=%0d required rdy=1 vld=0 busy=0 IDLE",
               cmd_rdy, rsp_vld, busy, dbg_state);
    end
  endtask

  initial begin
    total = 0; bad = 0; prev_req = 1'b0;
    arst_n = 1'b0; cmd_vld = 1'b0; cmd_is_wr = 1'b0; cmd_addr = '0; cmd_wr_data = '0;
    rsp_rdy = 1'b1; slv_vld = 1'b0; tb_vld = 1'b0; slv_data = '0; slv_cnt = 0;
    test_reset();
    test_write();
    test_read_latency();
    test_read();
    test_timeout(1'b1, 8'h00);
    test_timeout(1'b0, 8'h77);
    test_back_to_back();
    test_stray();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
